// File: rtl/frac_collect.sv
`default_nettype none
// ============================================================================
// Module   : frac_collect
// Brief    : Gathers one fractional sample per enabled channel into a capture
//            bank and hands a coherent snapshot downstream via valid/ready.
// Revision : 1.0
// ============================================================================
module frac_collect #(
    parameter int CTR_NUM = 4,
    parameter int DATA_W  = 7,
    parameter int TMO_W   = 8
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [CTR_NUM*DATA_W-1:0] in_data,
    input  logic [CTR_NUM-1:0]        in_wr,
    input  logic [CTR_NUM-1:0]        ch_mask,
    input  logic                      mode,
    input  logic [TMO_W-1:0]          timeout,
    output logic [CTR_NUM*DATA_W-1:0] out_data,
    output logic [CTR_NUM-1:0]        out_present,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [7:0]                drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CTR_NUM*DATA_W-1:0] cap_q, cap_d;
    logic [CTR_NUM*DATA_W-1:0] out_data_q, out_data_d;
    logic [CTR_NUM-1:0]        have_q, have_d;
    logic [CTR_NUM-1:0]        mask_q, mask_d;
    logic [CTR_NUM-1:0]        out_present_q, out_present_d;
    logic                      out_valid_q, out_valid_d;
    logic [TMO_W-1:0]          timer_q, timer_d;
    logic [7:0]                drop_cnt_q, drop_cnt_d;

    logic                      w_free, w_done, w_snap, w_start;
    logic [CTR_NUM-1:0]        w_en, w_empty, w_acc, w_drop;
    logic [4:0]                w_ndrop;
    logic [8:0]                w_sum;

    always_comb begin
        w_free  = !out_valid_q || out_ready;
        w_done  = (have_q == mask_q) || (mode && (timer_q == '0));
        w_snap  = w_free && (((state_q == COLLECT) && w_done) || (state_q == FLUSH));
        // A snapshot edge doubles as the first edge of a fresh collection.
        w_start = (state_q == IDLE) || w_snap;
        w_en    = w_start ? ch_mask : mask_q;
        w_empty = w_snap ? '1 : ~have_q;
        w_acc   = in_wr & w_en & w_empty;
        w_drop  = in_wr & w_en & ~w_empty;

        w_ndrop = '0;
        for (int i = 0; i < CTR_NUM; i++) begin
            w_ndrop = w_ndrop + 5'(w_drop[i]);
        end
        w_sum      = {1'b0, drop_cnt_q} + {4'b0, w_ndrop};
        drop_cnt_d = w_sum[8] ? 8'hFF : w_sum[7:0];

        cap_d  = cap_q;
        have_d = (w_snap ? '0 : have_q) | w_acc;
        for (int i = 0; i < CTR_NUM; i++) begin
            if (w_acc[i]) begin
                cap_d[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
            end
        end

        out_data_d    = out_data_q;
        out_present_d = out_present_q;
        out_valid_d   = out_valid_q;
        if (w_snap) begin
            for (int i = 0; i < CTR_NUM; i++) begin
                out_data_d[i*DATA_W +: DATA_W] = have_q[i] ? cap_q[i*DATA_W +: DATA_W] : '0;
            end
            out_present_d = have_q;
            out_valid_d   = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        state_d = state_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        if (w_start) begin
            if (|w_acc) begin
                state_d = COLLECT;
                mask_d  = ch_mask;
                timer_d = timeout;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == COLLECT) begin
            if (w_done) begin
                state_d = FLUSH;
            end else begin
                timer_d = timer_q - TMO_W'(timer_q != '0);
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cap_q         <= '0;
            have_q        <= '0;
            mask_q        <= '0;
            timer_q       <= '0;
            out_data_q    <= '0;
            out_present_q <= '0;
            out_valid_q   <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            have_q        <= have_d;
            mask_q        <= mask_d;
            timer_q       <= timer_d;
            out_data_q    <= out_data_d;
            out_present_q <= out_present_d;
            out_valid_q   <= out_valid_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_present = out_present_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != IDLE);
    assign drop_cnt    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_frac_collect
// Brief    : Directed and random stimulus for frac_collect against a
//            collection-level reference model.
// Revision : 1.0
// ============================================================================
module tb_frac_collect;

    localparam int CTR_NUM = 4;
    localparam int DATA_W  = 7;
    localparam int TMO_W   = 8;
    localparam int DW      = CTR_NUM * DATA_W;

    logic               clock = 1'b0;
    logic               rst;
    logic [DW-1:0]      in_data;
    logic [CTR_NUM-1:0] in_wr;
    logic [CTR_NUM-1:0] ch_mask;
    logic               mode;
    logic [TMO_W-1:0]   timeout;
    logic [DW-1:0]      out_data;
    logic [CTR_NUM-1:0] out_present;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic [7:0]         drop_cnt;

    int checks = 0;
    int errors = 0;

    frac_collect #(.CTR_NUM(CTR_NUM), .DATA_W(DATA_W), .TMO_W(TMO_W)) dut (
        .clock       (clock),
        .rst         (rst),
        .in_data     (in_data),
        .in_wr       (in_wr),
        .ch_mask     (ch_mask),
        .mode        (mode),
        .timeout     (timeout),
        .out_data    (out_data),
        .out_present (out_present),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: an open collection (with a "complete, waiting for the
    // output slot" flag), the captured samples, and the presented snapshot.
    bit m_active, m_complete, m_valid;
    bit m_have [CTR_NUM];
    bit m_mask [CTR_NUM];
    bit m_pres [CTR_NUM];
    int m_cap  [CTR_NUM];
    int m_out  [CTR_NUM];
    int m_timer, m_drops;

    task automatic model_reset();
        m_active = 0; m_complete = 0; m_valid = 0;
        m_timer = 0; m_drops = 0;
        for (int i = 0; i < CTR_NUM; i++) begin
            m_have[i] = 0; m_mask[i] = 0; m_pres[i] = 0; m_cap[i] = 0; m_out[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit all_in, done, snap, fresh, any_acc, en;
        all_in = 1;
        for (int i = 0; i < CTR_NUM; i++) if (m_have[i] != m_mask[i]) all_in = 0;
        done = m_active && (m_complete || all_in || (mode && m_timer == 0));
        snap = done && (!m_valid || out_ready);
        if (snap) begin
            for (int i = 0; i < CTR_NUM; i++) begin
                m_out[i]  = m_have[i] ? m_cap[i] : 0;
                m_pres[i] = m_have[i];
                m_have[i] = 0;
            end
            m_valid = 1; m_active = 0; m_complete = 0;
        end else begin
            if (out_ready) m_valid = 0;
            if (done) m_complete = 1;
            else if (m_active && m_timer > 0) m_timer--;
        end
        fresh = !m_active;
        any_acc = 0;
        for (int i = 0; i < CTR_NUM; i++) begin
            en = fresh ? ch_mask[i] : m_mask[i];
            if (in_wr[i] && en) begin
                if (!m_have[i]) begin
                    m_have[i] = 1;
                    m_cap[i]  = int'(in_data[i*DATA_W +: DATA_W]);
                    any_acc   = 1;
                end else if (m_drops < 255) begin
                    m_drops++;
                end
            end
        end
        if (fresh && any_acc) begin
            m_active = 1;
            m_timer  = int'(timeout);
            for (int i = 0; i < CTR_NUM; i++) m_mask[i] = ch_mask[i];
        end
    endtask

    function automatic logic [DW-1:0] data_vec();
        logic [DW-1:0] v = '0;
        for (int i = 0; i < CTR_NUM; i++) v[i*DATA_W +: DATA_W] = DATA_W'(m_out[i]);
        return v;
    endfunction

    function automatic logic [CTR_NUM-1:0] pres_vec();
        logic [CTR_NUM-1:0] v = '0;
        for (int i = 0; i < CTR_NUM; i++) v[i] = m_pres[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("busy",        64'(busy),        64'(m_active));
        check("out_valid",   64'(out_valid),   64'(m_valid));
        check("out_present", 64'(out_present), 64'(pres_vec()));
        check("out_data",    64'(out_data),    64'(data_vec()));
        check("drop_cnt",    64'(drop_cnt),    64'(m_drops));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic write1(input int ch, input int val);
        in_wr = '0;
        in_wr[ch] = 1'b1;
        in_data[ch*DATA_W +: DATA_W] = DATA_W'(val);
        tick();
    endtask

    task automatic idle();
        in_wr = '0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clock);
        #4;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        rst = 1'b0; in_data = '0; in_wr = '0; ch_mask = '0;
        mode = 1'b0; timeout = '0; out_ready = 1'b1;
        model_reset();
        #1;
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_busy",  64'(busy),      64'd0);
        check("reset_drop",  64'(drop_cnt),  64'd0);
        check("reset_data",  64'(out_data),  64'd0);
        do_reset();

        // All channels complete
        ch_mask = 4'hF; mode = 1'b0; out_ready = 1'b1;
        write1(0, 'h11); write1(1, 'h22); write1(2, 'h33); write1(3, 'h44);
        idle();
        check("t1_valid", 64'(out_valid),   64'd1);
        check("t1_data",  64'(out_data),    64'({7'h44, 7'h33, 7'h22, 7'h11}));
        check("t1_pres",  64'(out_present), 64'h0F);
        check("t1_drop",  64'(drop_cnt),    64'd0);
        idle();
        check("t1_valid_fall", 64'(out_valid), 64'd0);

        // Timeout partial snapshot
        mode = 1'b1; timeout = 8'd5;
        write1(1, 'h05);
        repeat (5) idle();
        check("t2_early", 64'(out_valid), 64'd0);
        idle();
        check("t2_valid", 64'(out_valid),   64'd1);
        check("t2_pres",  64'(out_present), 64'h2);
        check("t2_data",  64'(out_data),    64'({7'h0, 7'h0, 7'h05, 7'h0}));
        idle();

        // Duplicate write
        mode = 1'b0; ch_mask = 4'h3;
        write1(0, 1); write1(0, 2); write1(1, 3);
        idle();
        check("t3_drop", 64'(drop_cnt), 64'd1);
        check("t3_data", 64'(out_data), 64'({7'h0, 7'h0, 7'h03, 7'h01}));
        idle();

        // Backpressure
        out_ready = 1'b0;
        write1(0, 'h0A); write1(1, 'h0B); idle();
        check("t4_a_valid", 64'(out_valid), 64'd1);
        write1(0, 'h1A); write1(1, 'h1B); idle();
        check("t4_flush_busy", 64'(busy), 64'd1);
        write1(0, 'h2A); write1(0, 'h2B);
        check("t4_hold_data", 64'(out_data), 64'({7'h0, 7'h0, 7'h0B, 7'h0A}));
        check("t4_drop",      64'(drop_cnt), 64'd3);
        in_wr = '0; out_ready = 1'b1;
        tick();
        check("t4_b_valid", 64'(out_valid), 64'd1);
        check("t4_b_data",  64'(out_data),  64'({7'h0, 7'h0, 7'h1B, 7'h1A}));
        idle();
        check("t4_valid_fall", 64'(out_valid), 64'd0);

        // Write on the snapshot edge
        write1(0, 'h10); write1(1, 'h20); write1(0, 'h30);
        check("t5_data", 64'(out_data), 64'({7'h0, 7'h0, 7'h20, 7'h10}));
        check("t5_busy", 64'(busy),     64'd1);
        check("t5_drop", 64'(drop_cnt), 64'd3);
        write1(1, 'h40); idle();
        check("t5_next", 64'(out_data), 64'({7'h0, 7'h0, 7'h40, 7'h30}));

        // Reset mid-collection, then drop counter saturation
        write1(0, 'h55);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_busy",  64'(busy),        64'd0);
        check("t6_rst_valid", 64'(out_valid),   64'd0);
        check("t6_rst_pres",  64'(out_present), 64'd0);
        check("t6_rst_data",  64'(out_data),    64'd0);
        check("t6_rst_drop",  64'(drop_cnt),    64'd0);
        model_reset();
        @(posedge clock);
        #4 rst = 1'b1;
        in_wr = '0;
        repeat (3) idle();
        check("t6_no_snap", 64'(out_valid), 64'd0);
        ch_mask = 4'h3;
        write1(0, 'h01);
        for (int n = 0; n < 300; n++) write1(0, n);
        check("t6_sat", 64'(drop_cnt), 64'd255);

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 37 == 0) mode = 1'($urandom);
            timeout   = TMO_W'($urandom_range(0, 6));
            ch_mask   = CTR_NUM'($urandom);
            in_wr     = CTR_NUM'($urandom) & CTR_NUM'($urandom);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
